decode_stage: RTL and testbench
===============================

# decode_stage

Registered instruction-decode stage with a valid/ready handshake on both sides. It is the parametrised successor of the team's single-cycle control unit. It decodes the same MIPS-subset instruction set into ALU function, register indices, extended immediate, and memory/jump controls. Beyond that it adds back-pressure, flush, load-use bubble insertion, an illegal-instruction flag and saturating performance counters. It sits between instruction fetch and the register-file/ALU stage.

## Interface
- XLEN, 32, width of the extended immediate (must be at least 16)
- RA_W, 5, register index width (instruction fields are 5 bits, zero-extended to RA_W)
- CNT_W, 16, width of the performance counters
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- instruction  in  32  instruction word
- flush  in  1  discard the held result and block input this cycle
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream consumes the bundle
- alu_func  out  3  001 add, 010 sub, 011 and, 100 or, 101 slt, 000 none
- rs, rt, rd  out  RA_W each  register indices
- imm  out  XLEN  extended immediate
- jump_offset  out  16  raw jump offset (instruction[15:0])
- ram_load, ram_write, jump, imm_en, illegal  out  1 each  control flags
- decoded_cnt, bubble_cnt  out  CNT_W each  saturating counters

## Operation
- **Opcode field** is instruction[31:26]; funct is instruction[3:0].
- **R-type (op 000000):** rs=[25:21], rt=[20:16], rd=[15:11].
  - funct 0000 → add (001), 0010 → sub (010), 0100 → and (011), 0101 → or (100), 1010 → slt (101).
  - Any other funct → illegal.
- **I-type ALU:** op 001000 addi (001), 001100 andi (011), 001101 ori (100), 001010 slti (101).
  - imm_en=1, rs=[25:21], rt=[20:16], rd=0.
  - addi and slti sign-extend [15:0] to XLEN; andi and ori zero-extend.
- **lw (100011) / sw (101011):** ram_load or ram_write=1, rs=[25:21] (base), rt=[20:16], imm = sign-extended offset, alu_func=000.
- **j (000010):** jump=1, jump_offset=[15:0], all register indices 0.
- **Any other opcode:** illegal=1, all other controls 0. The bundle is still emitted with out_valid.
- Fields not used by an instruction are driven to 0. Exactly one of ram_load, ram_write, jump, imm_en and "R-type" is set for a legal instruction.
- **Source-register use:**
  - R-type reads rs and rt.
  - I-type ALU and lw read rs.
  - sw reads rs and rt.
  - j reads none.
- **hazard** = out_valid & ram_load(held) & rt(held)≠0 & in_valid & the incoming instruction reads rt(held).
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
- **Accept (in_valid & in_ready):** the output register loads the new bundle and out_valid=1. decoded_cnt increments.
- **Held bundle transferred with nothing accepted:** out_valid=0. If hazard was the cause, bubble_cnt increments (one bubble per load-use pair).
- **flush:** out_valid=0 at the next edge. No accept occurs and bubble_cnt is not incremented.
- **Counters** saturate at 2^CNT_W−1 and never wrap.

## Timing
- **Reset:** all outputs 0 (out_valid=0, counters 0). in_ready=1 whenever rst_n is high and flush is low.
- **Latency:** one cycle. The bundle appears the cycle after acceptance.
- **Throughput:** one instruction per cycle when out_ready is held high and there is no hazard.
- **Stall:** while out_valid & ~out_ready, the output bundle is held stable and in_ready=0.
- **Load-use:** the lw leaves in cycle N with in_ready=0. Cycle N+1 has out_valid=0 and the dependent instruction is accepted. Its bundle is valid in cycle N+2, which gives exactly one bubble.
- **flush together with out_ready and in_valid:** flush wins. Nothing is accepted and out_valid becomes 0.
- **Reset asserted mid-operation:** all state clears immediately (asynchronous). The first accept is possible on the first edge after deassertion.

## Test plan
- **Reset:** assert rst_n=0 → out_valid=0, decoded_cnt=0. After release, in_ready=1.
- **Back-to-back stream with out_ready=1:** add r3,r1,r2 (0x00221820), then addi r2,r1,-1 (0x2022FFFF), then andi r2,r1,0x8000 (0x30228000).
  - Bundles arrive one per cycle: alu 001/rd=3, imm=0xFFFFFFFF, imm=0x00008000.
  - decoded_cnt=3.
- **Load-use:** lw r5,4(r1) (0x8C250004) then add r6,r5,r0 (0x00A03020).
  - One out_valid=0 cycle between the two bundles; bubble_cnt=1.
  - Repeating with add r6,r7,r0 → no bubble.
- **Back-pressure:** out_ready=0 for 3 cycles while in_valid=1 → bundle held unchanged, in_ready=0, decoded_cnt does not advance.
- **Illegal instruction and flush:**
  - Opcode 111111 → illegal=1, alu_func=000.
  - flush while a bundle is held → out_valid=0 next cycle, bubble_cnt unchanged.
- **Saturation:** with CNT_W=2, accept 6 instructions → decoded_cnt=3.

Source files
------------

// File: rtl/decode_if.sv
// Handshake and decoded-bundle signals between fetch, the decode stage and
// the register-file/ALU stage. The stage uses the slave view; the
// surrounding pipeline (or a bench) uses the master view.
interface decode_if #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       alu_func;
    logic [RA_W-1:0]  rs;
    logic [RA_W-1:0]  rt;
    logic [RA_W-1:0]  rd;
    logic [XLEN-1:0]  imm;
    logic [15:0]      jump_offset;
    logic             ram_load;
    logic             ram_write;
    logic             jump;
    logic             imm_en;
    logic             illegal;
    logic [CNT_W-1:0] decoded_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    modport slave (
        input  in_valid, instruction, flush, out_ready,
        output in_ready, out_valid, alu_func, rs, rt, rd, imm, jump_offset,
               ram_load, ram_write, jump, imm_en, illegal, decoded_cnt, bubble_cnt
    );

    modport master (
        output in_valid, instruction, flush, out_ready,
        input  in_ready, out_valid, alu_func, rs, rt, rd, imm, jump_offset,
               ram_load, ram_write, jump, imm_en, illegal, decoded_cnt, bubble_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// Registered MIPS-subset decode stage with valid/ready on both sides,
// flush, load-use bubble insertion, illegal-opcode flag and saturating
// decode/bubble counters.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input logic     clk,
    input logic     rst_n,
    decode_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    // Widen a 16-bit immediate to XLEN; written bitwise so XLEN=16 works too.
    function automatic logic [XLEN-1:0] ext_imm(input logic [15:0] v, input logic sign_ext);
        logic [XLEN-1:0] r;
        r       = (sign_ext && v[15]) ? '1 : '0;
        r[15:0] = v;
        return r;
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [5:0]      op;
    logic [3:0]      funct;
    logic [RA_W-1:0] f_rs, f_rt, f_rd;

    logic [2:0]      d_alu;
    logic [RA_W-1:0] d_rs, d_rt, d_rd;
    logic [XLEN-1:0] d_imm;
    logic [15:0]     d_joff;
    logic            d_load, d_write, d_jump, d_imm_en, d_illegal;
    logic            use_rs, use_rt;

    logic [2:0]       alu_p1;
    logic [RA_W-1:0]  rs_p1, rt_p1, rd_p1;
    logic [XLEN-1:0]  imm_p1;
    logic [15:0]      joff_p1;
    logic             load_p1, write_p1, jump_p1, imm_en_p1, illegal_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] decoded_cnt_p1, bubble_cnt_p1;

    logic reads_held_rt, hazard, in_ready, accept, bubble;

    assign op    = bus.instruction[31:26];
    assign funct = bus.instruction[3:0];
    assign f_rs  = RA_W'(bus.instruction[25:21]);
    assign f_rt  = RA_W'(bus.instruction[20:16]);
    assign f_rd  = RA_W'(bus.instruction[15:11]);

    // Combinational decode of the incoming word; unused fields stay zero.
    always_comb begin
        d_alu     = ALU_NONE;
        d_rs      = '0;
        d_rt      = '0;
        d_rd      = '0;
        d_imm     = '0;
        d_joff    = '0;
        d_load    = 1'b0;
        d_write   = 1'b0;
        d_jump    = 1'b0;
        d_imm_en  = 1'b0;
        d_illegal = 1'b0;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    4'b0000: d_alu = ALU_ADD;
                    4'b0010: d_alu = ALU_SUB;
                    4'b0100: d_alu = ALU_AND;
                    4'b0101: d_alu = ALU_OR;
                    4'b1010: d_alu = ALU_SLT;
                    default: d_alu = ALU_NONE;
                endcase
                if (d_alu == ALU_NONE) begin
                    d_illegal = 1'b1;
                end else begin
                    d_rs   = f_rs;
                    d_rt   = f_rt;
                    d_rd   = f_rd;
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                end
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                case (op)
                    OP_ADDI: d_alu = ALU_ADD;
                    OP_ANDI: d_alu = ALU_AND;
                    OP_ORI:  d_alu = ALU_OR;
                    default: d_alu = ALU_SLT;
                endcase
                d_imm_en = 1'b1;
                d_rs     = f_rs;
                d_rt     = f_rt;
                use_rs   = 1'b1;
                d_imm    = ext_imm(bus.instruction[15:0], (op == OP_ADDI) || (op == OP_SLTI));
            end
            OP_LW: begin
                d_load = 1'b1;
                d_rs   = f_rs;
                d_rt   = f_rt;
                use_rs = 1'b1;
                d_imm  = ext_imm(bus.instruction[15:0], 1'b1);
            end
            OP_SW: begin
                d_write = 1'b1;
                d_rs    = f_rs;
                d_rt    = f_rt;
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                d_imm   = ext_imm(bus.instruction[15:0], 1'b1);
            end
            OP_J: begin
                d_jump = 1'b1;
                d_joff = bus.instruction[15:0];
            end
            default: d_illegal = 1'b1;
        endcase
    end

    // A held load whose destination the incoming word reads forces one bubble.
    assign reads_held_rt = (use_rs && (f_rs == rt_p1)) || (use_rt && (f_rt == rt_p1));
    assign hazard   = vld_p1 && load_p1 && (rt_p1 != '0) && bus.in_valid && reads_held_rt;
    assign in_ready = (!vld_p1 || bus.out_ready) && !hazard && !bus.flush;
    assign accept   = bus.in_valid && in_ready;
    assign bubble   = vld_p1 && bus.out_ready && hazard && !bus.flush;

    // Stage p0 -> p1: valid bit and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1         <= 1'b0;
            decoded_cnt_p1 <= '0;
            bubble_cnt_p1  <= '0;
        end else begin
            if (bus.flush)          vld_p1 <= 1'b0;
            else if (accept)        vld_p1 <= 1'b1;
            else if (bus.out_ready) vld_p1 <= 1'b0;
            if (accept) decoded_cnt_p1 <= sat_inc(decoded_cnt_p1);
            if (bubble) bubble_cnt_p1  <= sat_inc(bubble_cnt_p1);
        end
    end

    // Stage p0 -> p1: decoded bundle, loaded only on accept so stalls hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_p1     <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            rd_p1      <= '0;
            imm_p1     <= '0;
            joff_p1    <= '0;
            load_p1    <= 1'b0;
            write_p1   <= 1'b0;
            jump_p1    <= 1'b0;
            imm_en_p1  <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (accept) begin
            alu_p1     <= d_alu;
            rs_p1      <= d_rs;
            rt_p1      <= d_rt;
            rd_p1      <= d_rd;
            imm_p1     <= d_imm;
            joff_p1    <= d_joff;
            load_p1    <= d_load;
            write_p1   <= d_write;
            jump_p1    <= d_jump;
            imm_en_p1  <= d_imm_en;
            illegal_p1 <= d_illegal;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = vld_p1;
    assign bus.alu_func    = alu_p1;
    assign bus.rs          = rs_p1;
    assign bus.rt          = rt_p1;
    assign bus.rd          = rd_p1;
    assign bus.imm         = imm_p1;
    assign bus.jump_offset = joff_p1;
    assign bus.ram_load    = load_p1;
    assign bus.ram_write   = write_p1;
    assign bus.jump        = jump_p1;
    assign bus.imm_en      = imm_en_p1;
    assign bus.illegal     = illegal_p1;
    assign bus.decoded_cnt = decoded_cnt_p1;
    assign bus.bubble_cnt  = bubble_cnt_p1;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table plus handshake sequences.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) bus ();
    decode_if #(.XLEN(32), .RA_W(5), .CNT_W(2))  bus2 ();

    decode_stage #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    decode_stage #(.XLEN(32), .RA_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  alu;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
        logic [15:0] joff;
        logic [4:0]  flg; // ram_load, ram_write, jump, imm_en, illegal
    } vec_t;

    vec_t vecs[15];
    int checks = 0;
    int errors = 0;
    int exp_dec = 0;
    int exp_bub = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [70:0] act_bundle();
        return {bus.alu_func, bus.rs, bus.rt, bus.rd, bus.imm, bus.jump_offset,
                bus.ram_load, bus.ram_write, bus.jump, bus.imm_en, bus.illegal};
    endfunction

    initial begin
        vecs[0]  = '{32'h00221820, 3'b001, 5'd1, 5'd2, 5'd3, 32'h0, 16'h0, 5'b00000};
        vecs[1]  = '{32'h00221822, 3'b010, 5'd1, 5'd2, 5'd3, 32'h0, 16'h0, 5'b00000};
        vecs[2]  = '{32'h00221824, 3'b011, 5'd1, 5'd2, 5'd3, 32'h0, 16'h0, 5'b00000};
        vecs[3]  = '{32'h00221825, 3'b100, 5'd1, 5'd2, 5'd3, 32'h0, 16'h0, 5'b00000};
        vecs[4]  = '{32'h0022182A, 3'b101, 5'd1, 5'd2, 5'd3, 32'h0, 16'h0, 5'b00000};
        vecs[5]  = '{32'h00221821, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 16'h0, 5'b00001};
        vecs[6]  = '{32'h2022FFFF, 3'b001, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 16'h0, 5'b00010};
        vecs[7]  = '{32'h20227FFF, 3'b001, 5'd1, 5'd2, 5'd0, 32'h00007FFF, 16'h0, 5'b00010};
        vecs[8]  = '{32'h30228000, 3'b011, 5'd1, 5'd2, 5'd0, 32'h00008000, 16'h0, 5'b00010};
        vecs[9]  = '{32'h34228000, 3'b100, 5'd1, 5'd2, 5'd0, 32'h00008000, 16'h0, 5'b00010};
        vecs[10] = '{32'h2822FFFF, 3'b101, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 16'h0, 5'b00010};
        vecs[11] = '{32'h8C250004, 3'b000, 5'd1, 5'd5, 5'd0, 32'h00000004, 16'h0, 5'b10000};
        vecs[12] = '{32'hAC25FFFC, 3'b000, 5'd1, 5'd5, 5'd0, 32'hFFFFFFFC, 16'h0, 5'b01000};
        vecs[13] = '{32'h0800ABCD, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 16'hABCD, 5'b00100};
        vecs[14] = '{32'hFC221820, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 16'h0, 5'b00001};

        bus.in_valid = 1'b0;  bus.instruction = '0;  bus.flush = 1'b0;  bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.instruction = '0; bus2.flush = 1'b0; bus2.out_ready = 1'b1;

        // Reset
        #3;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_decoded_cnt", bus.decoded_cnt, 0);
        chk("rst_bubble_cnt", bus.bubble_cnt, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // Back-to-back stream
        bus.in_valid = 1'b1;
        bus.instruction = 32'h00221820;
        tick(); exp_dec++;
        chk("stream0_valid", bus.out_valid, 1);
        chk("stream0_alu_rd", {bus.alu_func, bus.rd}, {3'b001, 5'd3});
        bus.instruction = 32'h2022FFFF;
        tick(); exp_dec++;
        chk("stream1_valid", bus.out_valid, 1);
        chk("stream1_imm", bus.imm, 32'hFFFFFFFF);
        bus.instruction = 32'h30228000;
        tick(); exp_dec++;
        chk("stream2_valid", bus.out_valid, 1);
        chk("stream2_imm", bus.imm, 32'h00008000);
        bus.in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", bus.out_valid, 0);
        chk("stream_decoded_cnt", bus.decoded_cnt, 3);

        // Decode table
        for (int i = 0; i < 15; i++) begin
            bus.in_valid = 1'b1;
            bus.instruction = vecs[i].instr;
            tick(); exp_dec++;
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("vec%0d_bundle", i), act_bundle(),
                {vecs[i].alu, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm,
                 vecs[i].joff, vecs[i].flg});
            tick();
        end
        chk("table_decoded_cnt", bus.decoded_cnt, exp_dec);

        // Load-use with dependent add r6,r5,r0
        bus.in_valid = 1'b1;
        bus.instruction = 32'h8C250004;
        tick(); exp_dec++;
        chk("lu_lw_load", {bus.out_valid, bus.ram_load, bus.rt}, {1'b1, 1'b1, 5'd5});
        bus.instruction = 32'h00A03020;
        #1;
        chk("lu_hazard_in_ready", bus.in_ready, 0);
        tick(); exp_bub++;
        chk("lu_bubble_valid", bus.out_valid, 0);
        chk("lu_bubble_cnt", bus.bubble_cnt, exp_bub);
        chk("lu_after_in_ready", bus.in_ready, 1);
        tick(); exp_dec++;
        chk("lu_add_valid_rd", {bus.out_valid, bus.rs, bus.rd}, {1'b1, 5'd5, 5'd6});

        // Load followed by independent add r6,r7,r0
        bus.instruction = 32'h8C250004;
        tick(); exp_dec++;
        chk("nolu_lw_load", {bus.out_valid, bus.ram_load}, 2'b11);
        bus.instruction = 32'h00E03020;
        #1;
        chk("nolu_in_ready", bus.in_ready, 1);
        tick(); exp_dec++;
        chk("nolu_add_valid", {bus.out_valid, bus.rs, bus.rd}, {1'b1, 5'd7, 5'd6});
        bus.in_valid = 1'b0;
        tick();
        chk("nolu_bubble_cnt", bus.bubble_cnt, exp_bub);

        // Back-pressure
        bus.in_valid = 1'b1;
        bus.instruction = 32'h34228000;
        tick(); exp_dec++;
        bus.out_ready = 1'b0;
        bus.instruction = 32'h00221820;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), bus.in_ready, 0);
            chk($sformatf("bp%0d_held", c), {bus.out_valid, bus.alu_func, bus.imm},
                {1'b1, 3'b100, 32'h00008000});
            chk($sformatf("bp%0d_decoded_cnt", c), bus.decoded_cnt, exp_dec);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", bus.in_ready, 1);
        tick(); exp_dec++;
        chk("bp_next_bundle", {bus.out_valid, bus.alu_func}, {1'b1, 3'b001});
        bus.in_valid = 1'b0;
        tick();
        chk("bp_decoded_cnt", bus.decoded_cnt, exp_dec);

        // Flush wins over out_ready and in_valid
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.instruction = 32'h00221820;
        tick(); exp_dec++;
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        bus.instruction = 32'h00221822;
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_decoded_cnt", bus.decoded_cnt, exp_dec);
        chk("flush_bubble_cnt", bus.bubble_cnt, exp_bub);

        // Asynchronous reset mid-operation
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.instruction = 32'h00221820;
        tick();
        chk("arst_pre_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_counters", {bus.decoded_cnt, bus.bubble_cnt}, 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("arst_first_accept", {bus.out_valid, bus.decoded_cnt}, {1'b1, 16'd1});
        bus.in_valid = 1'b0;
        tick();

        // Counter saturation with CNT_W=2
        bus2.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus2.instruction = (i % 2 == 0) ? 32'h00221820 : 32'h2022FFFF;
            tick();
            if (i == 2) chk("sat_at_max", bus2.decoded_cnt, 3);
        end
        bus2.in_valid = 1'b0;
        tick();
        chk("sat_decoded_cnt", bus2.decoded_cnt, 3);
        chk("sat_bubble_cnt", bus2.bubble_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
